// File: rtl/sample_fill_ctrl.sv
// Watermark-driven refill scheduler: requests stereo samples and packs {L,R} into FIFO words.
// Optional macro UNDERRUN_CNT_EN enables the wr_empty rising-edge counter on underrun_cnt.
module sample_fill_ctrl #(
  parameter int USEDW_W   = 8,
  parameter int LOW_WM    = 64,
  parameter int HIGH_WM   = 192,
  parameter int TIMEOUT   = 255,
  parameter int USEDW_LAT = 2
) (
  input  logic                      FPGACLK,
  input  logic                      Reset,
  input  logic                      enable,
  input  logic [USEDW_W-1:0]        wr_usedw,
  input  logic                      wr_full,
  input  logic                      wr_empty,
  output logic                      fifo_wrreq,
  output logic [31:0]               fifo_data,
  output logic                      gen_req,
  input  logic                      gen_valid,
  input  logic signed [15:0]        gen_sample_l,
  input  logic signed [15:0]        gen_sample_r,
  output logic                      filling,
  output logic                      timeout_err,
  output logic [15:0]               underrun_cnt
);

  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = (USEDW_LAT > 1) ? $clog2(USEDW_LAT) : 1;

  localparam logic [USEDW_W-1:0] LOW_LVL   = USEDW_W'(LOW_WM);
  localparam logic [USEDW_W-1:0] HIGH_LVL  = USEDW_W'(HIGH_WM);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(USEDW_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [TMO_W-1:0]    tmo_cnt_nx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_cnt_nx;
  logic                filling_nx;
  logic                gen_req_nx;
  logic                wrreq_nx;
  logic                tmo_err_nx;
  logic                capture;
  logic                set_cond;
  logic                clr_cond;
  logic                tmo_hit;
  logic                hold_last;

  assign set_cond  = enable && (wr_usedw < LOW_LVL);
  assign clr_cond  = !enable || wr_full || (wr_usedw >= HIGH_LVL);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign hold_last = (hold_cnt == HOLD_LAST);

  always_ff @(posedge FPGACLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A stalled WRITE leaves only after the cycle in which fifo_wrreq was actually high.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if ((filling || set_cond) && !clr_cond) state_nx = S_REQ;
      S_REQ:   state_nx = S_WAIT;
      S_WAIT: begin
        if (gen_valid)    state_nx = S_WRITE;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      S_WRITE: if (fifo_wrreq) state_nx = S_HOLD;
      S_HOLD: begin
        if (hold_last) state_nx = (filling && !clr_cond) ? S_REQ : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    filling_nx  = filling;
    gen_req_nx  = (state_nx == S_REQ);
    wrreq_nx    = 1'b0;
    tmo_err_nx  = timeout_err;
    capture     = 1'b0;
    tmo_cnt_nx  = tmo_cnt;
    hold_cnt_nx = '0;
    unique case (state)
      S_IDLE: filling_nx = (filling || set_cond) && !clr_cond;
      S_REQ:  tmo_cnt_nx = '0;
      S_WAIT: begin
        if (gen_valid) begin
          capture  = 1'b1;
          wrreq_nx = !wr_full;
        end else if (tmo_hit) begin
          tmo_err_nx = 1'b1;
          filling_nx = 1'b0;
        end else begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
        end
      end
      // Only we write this FIFO, so not-full one cycle ahead stays not-full for the write.
      S_WRITE: if (!fifo_wrreq) wrreq_nx = !wr_full;
      S_HOLD: begin
        if (hold_last) filling_nx = filling && !clr_cond;
        else           hold_cnt_nx = hold_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge FPGACLK or posedge Reset) begin
    if (Reset) begin
      gen_req     <= 1'b0;
      fifo_wrreq  <= 1'b0;
      filling     <= 1'b0;
      timeout_err <= 1'b0;
      fifo_data   <= '0;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
    end else begin
      gen_req     <= gen_req_nx;
      fifo_wrreq  <= wrreq_nx;
      filling     <= filling_nx;
      timeout_err <= tmo_err_nx;
      tmo_cnt     <= tmo_cnt_nx;
      hold_cnt    <= hold_cnt_nx;
      if (capture) fifo_data <= {gen_sample_l, gen_sample_r};
    end
  end

`ifdef UNDERRUN_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        wr_empty_p0;
  logic [15:0] underrun_p1;

  // Stage 0: previous wr_empty, reset high so an empty FIFO at start-up is not an underrun.
  always_ff @(posedge FPGACLK or posedge Reset) begin
    if (Reset) begin
      wr_empty_p0 <= 1'b1;
      underrun_p1 <= '0;
    end else begin
      wr_empty_p0 <= wr_empty;
      if (enable && wr_empty && !wr_empty_p0) underrun_p1 <= sat_inc(underrun_p1);
    end
  end

  assign underrun_cnt = underrun_p1;
`else
  logic unused_empty;
  assign unused_empty = wr_empty;
  assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_fill_ctrl.sv
// Bench for sample_fill_ctrl: event-timeline reference model checked every cycle, plus directed cases.
module tb_sample_fill_ctrl;
  localparam int LOW_WM = 64, HIGH_WM = 192, TIMEOUT = 255, USEDW_LAT = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [7:0]         wr_usedw = 8'd0;
  logic               wr_full = 1'b0;
  logic               wr_empty = 1'b0;
  logic               fifo_wrreq;
  logic [31:0]        fifo_data;
  logic               gen_req;
  logic               gen_valid = 1'b0;
  logic signed [15:0] gen_sample_l = '0;
  logic signed [15:0] gen_sample_r = '0;
  logic               filling;
  logic               timeout_err;
  logic [15:0]        underrun_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sample_fill_ctrl #(
    .USEDW_W(8), .LOW_WM(LOW_WM), .HIGH_WM(HIGH_WM), .TIMEOUT(TIMEOUT), .USEDW_LAT(USEDW_LAT)
  ) dut (
    .FPGACLK(clk), .Reset(rst), .enable(enable), .wr_usedw(wr_usedw), .wr_full(wr_full),
    .wr_empty(wr_empty), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .gen_req(gen_req),
    .gen_valid(gen_valid), .gen_sample_l(gen_sample_l), .gen_sample_r(gen_sample_r),
    .filling(filling), .timeout_err(timeout_err), .underrun_cnt(underrun_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expected event times derived from the behavioural rules.
  int          cyc = 0;
  int          m_req_at, m_wr_at, m_win_end, m_idle_from;
  bit          m_wait, m_pend, m_fill, m_err, m_clr, m_we_prev;
  logic [31:0] m_data;
  logic [15:0] m_ucnt, m_ucnt_exp;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {26'd0, gen_req, fifo_wrreq, filling, timeout_err,
                            |fifo_data, |underrun_cnt}, 32'd0);
      m_req_at = -1000; m_wr_at = -1000; m_win_end = -1000; m_idle_from = 0;
      m_wait = 0; m_pend = 0; m_fill = 0; m_err = 0; m_data = '0;
      m_ucnt = '0; m_we_prev = 1;
    end else begin
`ifdef UNDERRUN_CNT_EN
      m_ucnt_exp = m_ucnt;
`else
      m_ucnt_exp = 16'h0000;
`endif
      chk("gen_req", gen_req, (cyc == m_req_at));
      chk("fifo_wrreq", fifo_wrreq, (cyc == m_wr_at));
      chk("filling", filling, m_fill);
      chk("timeout_err", timeout_err, m_err);
      chk("fifo_data", fifo_data, m_data);
      chk("underrun_cnt", underrun_cnt, m_ucnt_exp);

      m_clr = !enable || wr_full || (wr_usedw >= HIGH_WM);
      if (cyc == m_req_at) begin
        m_wait = 1; m_win_end = cyc + TIMEOUT;
      end else if (m_wait) begin
        if (gen_valid) begin
          m_wait = 0; m_pend = 1; m_data = {gen_sample_l, gen_sample_r};
        end else if (cyc == m_win_end) begin
          m_wait = 0; m_err = 1; m_fill = 0; m_idle_from = cyc + 1;
        end
      end
      if (m_pend && !wr_full) begin
        m_pend = 0; m_wr_at = cyc + 1;
      end
      if (cyc == m_wr_at + USEDW_LAT) begin
        if (!m_clr) m_req_at = cyc + 1;
        else begin m_fill = 0; m_idle_from = cyc + 1; end
      end else if (m_idle_from >= 0 && cyc >= m_idle_from &&
                   enable && wr_usedw < LOW_WM && !m_clr) begin
        m_req_at = cyc + 1; m_fill = 1; m_idle_from = -1;
      end
      if (enable && wr_empty && !m_we_prev && m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
      m_we_prev = wr_empty;
    end
    cyc++;
  end

  // Stimulus: generator responder, FIFO fill-level model and random disturbances.
  int          dcyc = 0, level = 10, gv_at = -1, dmax = 4, fixed_delay = 0;
  bit          silent = 0, drain_en = 0, spur_en = 0, rand_full = 0, rand_empty = 0;
  bit          fix_en = 0, wr_prev = 0;
  logic [15:0] fix_l = '0, fix_r = '0;

  task automatic set_level(input int v);
    level = v;
    wr_usedw = 8'(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    dcyc++;
    if (wr_prev && level < 255) level++;
    wr_prev = fifo_wrreq;
    if (drain_en && level > 0 && $urandom_range(0, 3) == 0) level--;
    if (gen_req && !silent)
      gv_at = dcyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, dmax)));
    gen_valid    = (dcyc == gv_at) || (spur_en && $urandom_range(0, 19) == 0);
    gen_sample_l = fix_en ? fix_l : 16'($urandom);
    gen_sample_r = fix_en ? fix_r : 16'($urandom);
    wr_usedw     = 8'(level);
    wr_full      = rand_full && ($urandom_range(0, 9) == 0);
    wr_empty     = (level == 0) || (rand_empty && $urandom_range(0, 39) == 0);
  endtask

  task automatic wait_sig(input int which, input int budget, input string name, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((which == 0 && gen_req) || (which == 1 && fifo_wrreq) || (which == 2 && timeout_err)) begin
        at = dcyc;
        break;
      end
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1; gv_at = -1;
    repeat (2) step();
    rst = 0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, w, t, r2, cnt;
    bit saw, done;
    repeat (3) step();
    chk("rst_gen_req", gen_req, 0);
    chk("rst_filling", filling, 0);
    chk("rst_data", fifo_data, 0);
    rst = 0;

    // Basic transaction: answer 3 cycles after the request
    fix_en = 1; fix_l = 16'hABCD; fix_r = 16'h0123; fixed_delay = 3;
    set_level(10); enable = 1;
    wait_sig(0, 10, "t2_req", r);
    wait_sig(1, 10, "t2_wr", w);
    chk("t2_latency", w - r, 4);
    chk("t2_data", fifo_data, 32'hABCD0123);
    step();
    chk("t2_wr_single", fifo_wrreq, 0);
    enable = 0;
    repeat (20) step();

    // Reset in the middle of WAIT, sample still pending
    set_level(10); enable = 1; fix_l = 16'h1234; fixed_delay = 5;
    wait_sig(0, 10, "t1_req", r);
    step(); step();
    rst = 1;
    #1;
    chk("t1_async_outputs", {28'd0, gen_req, fifo_wrreq, filling, timeout_err}, 0);
    chk("t1_async_data", fifo_data, 0);
    enable = 0;
    step();
    rst = 0;
    cnt = 0;
    repeat (12) begin step(); cnt += fifo_wrreq + gen_req; end
    chk("t1_no_write_after", cnt, 0);

    // Hysteresis burst from 60 up to the high watermark
    fix_en = 0; fixed_delay = 0; dmax = 4;
    set_level(60); enable = 1; saw = 0; done = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (filling && !saw) begin saw = 1; chk("t3_start_level", wr_usedw, 60); end
      if (saw && !filling) begin done = 1; break; end
    end
    chk("t3_burst_ended", done, 1);
    chk("t3_stop_level", level, 192);
    cnt = 0;
    repeat (200) begin step(); cnt += gen_req; end
    chk("t3_no_restart_high", cnt, 0);
    set_level(64);
    cnt = 0;
    repeat (20) begin step(); cnt += gen_req; end
    chk("t3_no_restart_at_low", cnt, 0);
    set_level(63);
    wait_sig(0, 5, "t3_restart_below_low", r);
    enable = 0;
    repeat (20) step();

    // Silent generator: timeout after exactly TIMEOUT wait cycles
    silent = 1; set_level(10); enable = 1;
    wait_sig(0, 10, "t4_req", r);
    wait_sig(2, 400, "t4_timeout", t);
    chk("t4_timeout_cycles", t - r, 256);
    chk("t4_filling_cleared", filling, 0);
    wait_sig(0, 5, "t4_rerequest", r2);
    chk("t4_rerequest_delay", r2 - t, 1);
    step();
    chk("t4_sticky", timeout_err, 1);
    silent = 0; enable = 0;
    do_reset();
    chk("t4_err_cleared", timeout_err, 0);

    // FIFO full for 5 cycles while a word is pending
    fix_en = 1; fix_l = 16'h5555; fix_r = 16'hAAAA; fixed_delay = 2;
    set_level(10); enable = 1;
    wait_sig(0, 10, "t5_req", r);
    step();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin step(); wr_full = 1; cnt += fifo_wrreq; end
    step();
    cnt += fifo_wrreq;
    chk("t5_no_write_while_full", cnt, 0);
    step();
    chk("t5_write_after_full", fifo_wrreq, 1);
    chk("t5_data", fifo_data, 32'h5555AAAA);
    enable = 0;
    step();
    chk("t5_single_write", fifo_wrreq, 0);
    repeat (15) step();

    // wr_empty pulses: one ignored while disabled, three counted
    do_reset();
    set_level(100); enable = 0;
    step(); wr_empty = 1; step(); step();
    enable = 1;
    for (int k = 0; k < 3; k++) begin step(); wr_empty = 1; step(); step(); end
    repeat (3) step();
`ifdef UNDERRUN_CNT_EN
    chk("t6_underrun", underrun_cnt, 3);
`else
    chk("t6_underrun", underrun_cnt, 0);
`endif

    // Randomised traffic against the model
    do_reset();
    fix_en = 0; fixed_delay = 0; dmax = 8; drain_en = 1; spur_en = 1;
    rand_full = 1; rand_empty = 1;
    set_level($urandom_range(40, 120)); enable = 1;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (i % 50 == 0) enable = ($urandom_range(0, 5) != 0);
      silent = ((i / 700) % 4 == 2);
    end
    silent = 0; enable = 0;
    repeat (300) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
